// File: rtl/reorder_pkg.sv
// Shared constants for the per-lane reorder stage.
// The slot entry struct is declared inside reorder_buffer because it depends on its data_t.
package reorder_pkg;

    localparam int DEFAULT_DEPTH = 64;

endpackage

// File: rtl/reorder_slot_ram.sv
// Entry storage for the reorder buffer: synchronous write, asynchronous read, no reset,
// so it maps onto distributed RAM. Slot validity is tracked separately by the top.
module reorder_slot_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/reorder_buffer.sv
// Reorders tagged values (tag = serial mod DEPTH) into a strictly in-order output stream.
// Define REORDER_BUFFER_OVERFLOW_CHECK_EN to drop writes to occupied slots and raise sticky overflow_o.
module reorder_buffer
    import reorder_pkg::*;
#(
    parameter type data_t   = logic [31:0],
    parameter int  DEPTH    = DEFAULT_DEPTH,
    localparam int TAG_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  data_t                in_data_i,
    input  logic [TAG_WIDTH-1:0] in_tag_i,
    input  logic                 in_keep_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output data_t                out_data_o,
    output logic                 out_keep_o,
    output logic                 out_last_o,
    output logic                 overflow_o
);

    typedef struct packed {
        data_t data;
        logic  keep;
        logic  last;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [DEPTH-1:0]     occupied_q, occupied_d;
    logic [TAG_WIDTH-1:0] head_q, head_d;
    entry_t               outEntry_q;
    logic                 outValid_q;

    entry_t wrEntry;
    entry_t rdEntry;
    logic   wrAccept;
    logic   wrEn;
    logic   load;

    // No back-pressure: the upstream credit loop bounds occupancy, so ready only drops in reset.
    assign in_ready_o = ~rst;
    assign wrAccept   = in_valid_i && in_ready_o;
    assign wrEntry    = '{data: in_data_i, keep: in_keep_i, last: in_last_i};

`ifdef REORDER_BUFFER_OVERFLOW_CHECK_EN
    logic overflow_q;

    assign wrEn       = wrAccept && !occupied_q[in_tag_i];
    assign overflow_o = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (wrAccept && occupied_q[in_tag_i]) begin
            overflow_q <= 1'b1;
        end
    end
`else
    assign wrEn       = wrAccept;
    assign overflow_o = 1'b0;
`endif

    assign load = occupied_q[head_q] && (!outValid_q || out_ready_i);

    // A write landing on the slot being loaded re-marks it occupied; the load still takes the old contents.
    always_comb begin
        occupied_d = occupied_q;
        head_d     = head_q;
        if (load) begin
            occupied_d[head_q] = 1'b0;
            head_d             = head_q + 1'b1;
        end
        if (wrEn) begin
            occupied_d[in_tag_i] = 1'b1;
        end
    end

    reorder_slot_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_slot_ram (
        .clk     (clk),
        .we_i    (wrEn),
        .waddr_i (in_tag_i),
        .wdata_i (wrEntry),
        .raddr_i (head_q),
        .rdata_o (rdEntry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupied_q <= '0;
            head_q     <= '0;
            outEntry_q <= '0;
            outValid_q <= 1'b0;
        end else begin
            occupied_q <= occupied_d;
            head_q     <= head_d;
            if (load) begin
                outEntry_q <= rdEntry;
                outValid_q <= 1'b1;
            end else if (out_ready_i) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = outValid_q;
    assign out_data_o  = outEntry_q.data;
    assign out_keep_o  = outEntry_q.keep;
    assign out_last_o  = outEntry_q.last;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer at DEPTH = 4 with an 8-bit payload.
// Honours REORDER_BUFFER_OVERFLOW_CHECK_EN for the overflow expectations.
module tb_reorder_buffer;

    localparam int DEPTH = 4;
    localparam int TW    = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic [TW-1:0] in_tag;
    logic          in_keep;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_keep;
    logic          out_last;
    logic          overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [9:0] expQ [$];
    logic [9:0] modelMem [DEPTH];
    logic       modelOcc [DEPTH];
    int         modelHead;
    logic       expOverflow;

    reorder_buffer #(
        .data_t (logic [7:0]),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_tag_i    (in_tag),
        .in_keep_i   (in_keep),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_keep_o  (out_keep),
        .out_last_o  (out_last),
        .overflow_o  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference ordering model: accepted entries are released to the scoreboard in serial order.
    task automatic modelWrite(input int tag, input logic [9:0] entry);
`ifdef REORDER_BUFFER_OVERFLOW_CHECK_EN
        if (modelOcc[tag]) begin
            expOverflow = 1'b1;
            return;
        end
`endif
        modelMem[tag] = entry;
        modelOcc[tag] = 1'b1;
        while (modelOcc[modelHead]) begin
            expQ.push_back(modelMem[modelHead]);
            modelOcc[modelHead] = 1'b0;
            modelHead = (modelHead + 1) % DEPTH;
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        for (int i = 0; i < DEPTH; i++) modelOcc[i] = 1'b0;
        modelHead   = 0;
        expOverflow = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int tag, input logic [7:0] data, input logic keep, input logic last);
        in_valid = 1'b1;
        in_tag   = TW'(tag);
        in_data  = data;
        in_keep  = keep;
        in_last  = last;
        modelWrite(tag, {data, keep, last});
        tick(1);
        in_valid = 1'b0;
    endtask

    // Every output handshake is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousOutput", {22'd0, out_data, out_keep, out_last}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("outEntry", {22'd0, out_data, out_keep, out_last}, {22'd0, expQ.pop_front()});
            end
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_tag    = '0;
        in_data   = '0;
        in_keep   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        modelReset();
        #2 rst = 1'b1;
        tick(3);
        checkOutput("resetOutValid", {31'd0, out_valid}, 0);
        checkOutput("resetOutData", {22'd0, out_data, out_keep, out_last}, 0);
        checkOutput("resetInReady", {31'd0, in_ready}, 0);
        checkOutput("resetOverflow", {31'd0, overflow}, 0);
        rst = 1'b0;
        tick(1);
        checkOutput("inReadyAfterReset", {31'd0, in_ready}, 1);

        // In-order: first element visible one cycle after its write, then back-to-back.
        out_ready = 1'b1;
        applyStimulus(0, 8'd10, 1'b1, 1'b0);
        checkOutput("inorderLatency", {31'd0, out_valid}, 0);
        applyStimulus(1, 8'd11, 1'b1, 1'b0);
        checkOutput("inorderValid1", {31'd0, out_valid}, 1);
        applyStimulus(2, 8'd12, 1'b1, 1'b0);
        checkOutput("inorderValid2", {31'd0, out_valid}, 1);
        applyStimulus(3, 8'd13, 1'b1, 1'b1);
        checkOutput("inorderValid3", {31'd0, out_valid}, 1);
        tick(1);
        checkOutput("inorderValid4", {31'd0, out_valid}, 1);
        tick(1);
        checkOutput("inorderIdle", {31'd0, out_valid}, 0);

        // Reverse: nothing until serial 0 arrives, then four consecutive outputs.
        applyStimulus(3, 8'hA3, 1'b1, 1'b1);
        checkOutput("reverseHold3", {31'd0, out_valid}, 0);
        applyStimulus(2, 8'hA2, 1'b1, 1'b0);
        checkOutput("reverseHold2", {31'd0, out_valid}, 0);
        applyStimulus(1, 8'hA1, 1'b0, 1'b0);
        checkOutput("reverseHold1", {31'd0, out_valid}, 0);
        applyStimulus(0, 8'hA0, 1'b1, 1'b0);
        checkOutput("reverseLatency", {31'd0, out_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("reverseBurst", {31'd0, out_valid}, 1);
        end
        tick(1);
        checkOutput("reverseIdle", {31'd0, out_valid}, 0);

        // Back-pressure: output holds serial 0 stable, then drains in four cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(i, 8'hB0 + 8'(i), 1'b1, i == 3);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("bpValid", {31'd0, out_valid}, 1);
            checkOutput("bpStable", {24'd0, out_data}, 32'hB0);
        end
        out_ready = 1'b1;
        tick(4);
        checkOutput("bpDrained", {31'd0, out_valid}, 0);

        // Wrap: serials 0..9 written with each pair swapped; head ends at 2.
        for (int p = 0; p < 5; p++) begin
            applyStimulus((2 * p + 1) % DEPTH, 8'h20 + 8'(2 * p + 1), 1'b1, 1'b0);
            applyStimulus((2 * p) % DEPTH, 8'h20 + 8'(2 * p), 1'b1, 1'b0);
        end
        tick(3);
        checkOutput("wrapIdle", {31'd0, out_valid}, 0);
        applyStimulus(2, 8'hC2, 1'b0, 1'b1);
        tick(1);
        checkOutput("wrapHeadAt2", {31'd0, out_valid}, 1);
        tick(1);

        // Reset mid-operation discards buffered entries.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus((modelHead + i) % DEPTH, 8'hD0 + 8'(i), 1'b1, 1'b0);
        checkOutput("preResetValid", {31'd0, out_valid}, 1);
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("resetAsyncValid", {31'd0, out_valid}, 0);
        checkOutput("resetAsyncReady", {31'd0, in_ready}, 0);
        tick(1);
        rst       = 1'b0;
        out_ready = 1'b1;
        applyStimulus(0, 8'h07, 1'b1, 1'b0);
        tick(1);
        checkOutput("postResetValid", {31'd0, out_valid}, 1);
        tick(3);
        checkOutput("noStaleEntries", {31'd0, out_valid}, 0);

        // Overflow: two writes to tag 2 while serial 1 is outstanding.
        applyStimulus(2, 8'h55, 1'b1, 1'b0);
        checkOutput("overflowBefore", {31'd0, overflow}, 0);
        applyStimulus(2, 8'h66, 1'b1, 1'b0);
        checkOutput("overflowFlag", {31'd0, overflow}, {31'd0, expOverflow});
        applyStimulus(1, 8'h11, 1'b1, 1'b0);
        tick(3);
        checkOutput("overflowSticky", {31'd0, overflow}, {31'd0, expOverflow});

        for (int i = 0; i < 20 && expQ.size() != 0; i++) tick(1);
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
